// File: rtl/regfile_scoreboard.sv
// Integer register file with writeback bypass and a per-register busy scoreboard
// that raises a combinational stall on RAW/WAW hazards against in-flight writes.
module regfile_scoreboard #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned NREG = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            write_reg,
   input  logic [4:0]      dstreg_addr,
   input  logic [XLEN-1:0] dstreg_data,
   input  logic [4:0]      rs1_addr,
   input  logic [4:0]      rs2_addr,
   input  logic            rs1_use,
   input  logic            rs2_use,
   input  logic            issue_valid,
   input  logic            issue_we,
   input  logic [4:0]      issue_rd,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   output logic            stall,
   output logic [NREG-1:0] busy_vec
);

   logic [NREG-1:0][XLEN-1:0] regs_q, regs_d;
   logic [NREG-1:0]           busy_q, busy_d;
   logic [NREG-1:0]           ebusy_c;
   logic                      retire_c;
   logic                      accept_c;

   assign retire_c = write_reg && (dstreg_addr != 5'd0);

   // A register retiring this cycle is not a hazard: the bypass supplies its data.
   always_comb begin
      ebusy_c = busy_q;
      if (write_reg) begin
         ebusy_c[dstreg_addr] = 1'b0;
      end
   end

   assign stall = issue_valid &&
                  ((rs1_use  && ebusy_c[rs1_addr]) ||
                   (rs2_use  && ebusy_c[rs2_addr]) ||
                   (issue_we && ebusy_c[issue_rd]));

   assign accept_c = issue_valid && issue_we && (issue_rd != 5'd0) && !stall;

   // Operand read: x0 is zero, then same-cycle writeback bypass, then storage.
   always_comb begin
      rs1_data = regs_q[rs1_addr];
      if (write_reg && (dstreg_addr == rs1_addr)) begin
         rs1_data = dstreg_data;
      end
      if (rs1_addr == 5'd0) begin
         rs1_data = '0;
      end

      rs2_data = regs_q[rs2_addr];
      if (write_reg && (dstreg_addr == rs2_addr)) begin
         rs2_data = dstreg_data;
      end
      if (rs2_addr == 5'd0) begin
         rs2_data = '0;
      end
   end

   // Next state: retire clears, accepted issue sets (set applied last so it wins).
   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      if (retire_c) begin
         regs_d[dstreg_addr] = dstreg_data;
         busy_d[dstreg_addr] = 1'b0;
      end
      if (accept_c) begin
         busy_d[issue_rd] = 1'b1;
      end
      regs_d[0] = '0;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs_q <= '0;
         busy_q <= '0;
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
      end
   end

   assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios plus randomized
// traffic, compared against an array-based reference model.
module tb_regfile_scoreboard;

   logic        clk;
   logic        rst_n;
   logic        write_reg;
   logic [4:0]  dstreg_addr;
   logic [31:0] dstreg_data;
   logic [4:0]  rs1_addr, rs2_addr;
   logic        rs1_use, rs2_use;
   logic        issue_valid, issue_we;
   logic [4:0]  issue_rd;
   logic [31:0] rs1_data, rs2_data;
   logic        stall;
   logic [31:0] busy_vec;

   int n_checks;
   int n_fail;

   logic [31:0] mregs [32];
   bit          mbusy [32];

   regfile_scoreboard #(.XLEN(32), .NREG(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .write_reg(write_reg), .dstreg_addr(dstreg_addr), .dstreg_data(dstreg_data),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_use(rs1_use), .rs2_use(rs2_use),
      .issue_valid(issue_valid), .issue_we(issue_we), .issue_rd(issue_rd),
      .rs1_data(rs1_data), .rs2_data(rs2_data),
      .stall(stall), .busy_vec(busy_vec)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- reference model ----------------
   function automatic logic [31:0] m_rd(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (write_reg && dstreg_addr == a) return dstreg_data;
      return mregs[a];
   endfunction

   function automatic bit m_ebusy(input logic [4:0] r);
      return mbusy[r] && !(write_reg && dstreg_addr == r);
   endfunction

   function automatic bit m_stall();
      return issue_valid && ((rs1_use && m_ebusy(rs1_addr)) ||
                             (rs2_use && m_ebusy(rs2_addr)) ||
                             (issue_we && m_ebusy(issue_rd)));
   endfunction

   function automatic logic [31:0] m_busy_vec();
      logic [31:0] v;
      for (int i = 0; i < 32; i++) v[i] = mbusy[i];
      return v;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 32; i++) begin
         mregs[i] = 32'd0;
         mbusy[i] = 1'b0;
      end
   endtask

   // Advance one clock; the model applies the rules using the pre-edge inputs.
   task automatic tick();
      bit          do_wr, do_set, in_rst;
      logic [4:0]  wa, ra;
      logic [31:0] wd;
      in_rst = !rst_n;
      do_wr  = write_reg && dstreg_addr != 5'd0;
      wa     = dstreg_addr;
      wd     = dstreg_data;
      do_set = issue_valid && issue_we && issue_rd != 5'd0 && !m_stall();
      ra     = issue_rd;
      @(posedge clk);
      if (!in_rst) begin
         if (do_wr) begin
            mregs[wa] = wd;
            mbusy[wa] = 1'b0;
         end
         if (do_set) mbusy[ra] = 1'b1;
      end
      #1;
   endtask

   task automatic idle();
      write_reg = 0; dstreg_addr = 0; dstreg_data = 0;
      rs1_addr = 0; rs2_addr = 0; rs1_use = 0; rs2_use = 0;
      issue_valid = 0; issue_we = 0; issue_rd = 0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      idle();
      rst_n = 1'b0;
      model_clear();
      #12 rst_n = 1'b1;
      #1;
      for (int a = 0; a < 32; a++) begin
         rs1_addr = 5'(a);
         rs2_addr = 5'(31 - a);
         #1;
         n_checks++;
         if (rs1_data !== 32'd0 || rs2_data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_read x%0d: got rs1=%h rs2=%h, want 0", a, rs1_data, rs2_data);
         end
      end
      n_checks++;
      if (busy_vec !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_busy: got %h, want 0", busy_vec);
      end
      write_reg = 1; dstreg_addr = 0; dstreg_data = 32'hDEADBEEF;
      rs1_addr = 0;
      tick();
      idle();
      #1;
      n_checks++;
      if (rs1_data !== 32'd0 || busy_vec !== 32'd0) begin
         n_fail++;
         $display("FAIL x0_write: got rs1=%h busy=%h, want 0/0", rs1_data, busy_vec);
      end
   endtask

   task automatic test_bypass();
      idle();
      write_reg = 1; dstreg_addr = 5; dstreg_data = 32'h12345678; rs1_addr = 5;
      #1;
      n_checks++;
      if (rs1_data !== 32'h12345678) begin
         n_fail++;
         $display("FAIL bypass_same_cycle: got %h, want 12345678", rs1_data);
      end
      tick();
      write_reg = 0;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_checks++;
         if (rs1_data !== 32'h12345678) begin
            n_fail++;
            $display("FAIL stored_read c%0d: got %h, want 12345678", c, rs1_data);
         end
         tick();
      end
      write_reg = 1; dstreg_addr = 6; dstreg_data = 32'hCAFEF00D; rs2_addr = 5;
      #1;
      n_checks++;
      if (rs2_data !== 32'h12345678) begin
         n_fail++;
         $display("FAIL other_write_no_bypass: got %h, want 12345678", rs2_data);
      end
      tick();
      idle();
   endtask

   task automatic test_raw();
      logic [31:0] bv;
      idle();
      issue_valid = 1; issue_we = 1; issue_rd = 7;
      #1;
      n_checks++;
      if (stall !== 1'b0) begin
         n_fail++;
         $display("FAIL raw_first_issue_stall: got %b, want 0", stall);
      end
      tick();
      idle();
      n_checks++;
      if (busy_vec[7] !== 1'b1) begin
         n_fail++;
         $display("FAIL raw_busy_set: got %b, want 1", busy_vec[7]);
      end
      bv = m_busy_vec();
      issue_valid = 1; rs1_use = 1; rs1_addr = 7; issue_we = 1; issue_rd = 12;
      #1;
      n_checks++;
      if (stall !== 1'b1) begin
         n_fail++;
         $display("FAIL raw_stall: got %b, want 1", stall);
      end
      tick();
      n_checks++;
      if (busy_vec !== bv) begin
         n_fail++;
         $display("FAIL raw_sb_unchanged: got %h, want %h", busy_vec, bv);
      end
      write_reg = 1; dstreg_addr = 7; dstreg_data = 32'hA5A5A5A5;
      #1;
      n_checks++;
      if (stall !== 1'b0 || rs1_data !== 32'hA5A5A5A5) begin
         n_fail++;
         $display("FAIL raw_release: got stall=%b rs1=%h, want 0/a5a5a5a5", stall, rs1_data);
      end
      tick();
      idle();
      n_checks++;
      if (busy_vec !== m_busy_vec()) begin
         n_fail++;
         $display("FAIL raw_after_wb_busy: got %h, want %h", busy_vec, m_busy_vec());
      end
      write_reg = 1; dstreg_addr = 12; dstreg_data = 32'h1;
      tick();
      idle();
   endtask

   task automatic test_waw();
      idle();
      issue_valid = 1; issue_we = 1; issue_rd = 9;
      tick();
      #1;
      n_checks++;
      if (stall !== 1'b1) begin
         n_fail++;
         $display("FAIL waw_stall: got %b, want 1", stall);
      end
      tick();
      write_reg = 1; dstreg_addr = 9; dstreg_data = 32'h99;
      #1;
      n_checks++;
      if (stall !== 1'b0) begin
         n_fail++;
         $display("FAIL waw_retire_issue_stall: got %b, want 0", stall);
      end
      tick();
      idle();
      n_checks++;
      if (busy_vec[9] !== 1'b1) begin
         n_fail++;
         $display("FAIL waw_set_wins: got %b, want 1", busy_vec[9]);
      end
      write_reg = 1; dstreg_addr = 9; dstreg_data = 32'h9A;
      tick();
      idle();
   endtask

   task automatic test_use_gating();
      idle();
      issue_valid = 1; issue_we = 1; issue_rd = 3;
      tick();
      issue_we = 0; issue_rd = 0; rs1_addr = 3; rs1_use = 0;
      #1;
      n_checks++;
      if (stall !== 1'b0) begin
         n_fail++;
         $display("FAIL use_gated: got %b, want 0", stall);
      end
      rs2_addr = 3; rs2_use = 1;
      #1;
      n_checks++;
      if (stall !== 1'b1) begin
         n_fail++;
         $display("FAIL rs2_use_stall: got %b, want 1", stall);
      end
      idle();
      write_reg = 1; dstreg_addr = 3; dstreg_data = 32'h3;
      tick();
      idle();
   endtask

   task automatic test_async_reset();
      idle();
      write_reg = 1; dstreg_addr = 4; dstreg_data = 32'h55;
      issue_valid = 1; issue_we = 1; issue_rd = 4;
      tick();
      idle();
      rs1_addr = 4;
      #1;
      n_checks++;
      if (rs1_data !== 32'h55 || busy_vec[4] !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_reset_state: got rs1=%h busy4=%b, want 55/1", rs1_data, busy_vec[4]);
      end
      #1;
      rst_n = 1'b0;
      model_clear();
      write_reg = 1; dstreg_addr = 8; dstreg_data = 32'h77; rs2_addr = 8;
      #1;
      n_checks++;
      if (rs1_data !== 32'd0 || busy_vec !== 32'd0) begin
         n_fail++;
         $display("FAIL async_reset_clear: got rs1=%h busy=%h, want 0/0", rs1_data, busy_vec);
      end
      n_checks++;
      if (rs2_data !== 32'h77) begin
         n_fail++;
         $display("FAIL reset_bypass: got %h, want 77", rs2_data);
      end
      tick();
      #2;
      write_reg = 0;
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (rs2_data !== 32'd0) begin
         n_fail++;
         $display("FAIL write_during_reset: got %h, want 0", rs2_data);
      end
      idle();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         write_reg   = 1'($urandom_range(0, 1));
         dstreg_addr = 5'($urandom_range(0, 7));
         dstreg_data = $urandom;
         rs1_addr    = 5'($urandom_range(0, 7));
         rs2_addr    = 5'($urandom_range(0, 7));
         rs1_use     = 1'($urandom_range(0, 1));
         rs2_use     = 1'($urandom_range(0, 1));
         issue_valid = 1'($urandom_range(0, 1));
         issue_we    = 1'($urandom_range(0, 1));
         issue_rd    = 5'($urandom_range(0, 7));
         #1;
         n_checks++;
         if (rs1_data !== m_rd(rs1_addr) || rs2_data !== m_rd(rs2_addr)) begin
            n_fail++;
            $display("FAIL rand_read c%0d: got %h/%h, want %h/%h", c, rs1_data, rs2_data,
                     m_rd(rs1_addr), m_rd(rs2_addr));
         end
         n_checks++;
         if (stall !== m_stall() || busy_vec !== m_busy_vec()) begin
            n_fail++;
            $display("FAIL rand_sb c%0d: got stall=%b busy=%h, want %b/%h", c, stall, busy_vec,
                     m_stall(), m_busy_vec());
         end
         tick();
      end
      idle();
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_bypass();
      test_raw();
      test_waw();
      test_use_gating();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
